tpi_port_core: RTL and testbench
================================

Name: tpi_port_core

Overview:
- Parametrised, fully synchronous successor of the TCBM 6523 TPI emulation.
- Provides three GPIO ports with per-bit direction registers, plus a control register. In interrupt mode the control register enables latched edge interrupts on PC[4:0], prioritised IRQ with acknowledge, and CA/CB handshake.
- Sits between the PLA/address decode (which supplies a qualified chip select) and the top-level tristate pads of the TCBM/IEC paddle.

Parameters:
PA_W, 8, implemented width of port A (1..8)
PB_W, 8, implemented width of port B (1..8)
PC_W, 8, implemented width of port C (1..8); interrupt mode requires 8
SYNC_STAGES, 2, input synchroniser depth for all port inputs (1..3)

Ports:
phi2  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
cs  in  1  qualified chip select; one access per cycle with cs=1
we  in  1  1=write, 0=read (valid with cs)
rs  in  3  register select
wdata  in  8  CPU write data
rdata  out  8  CPU read data (combinational from registers)
rdata_oe  out  1  cs & !we; top level drives data bus when high
pa_in/pa_out/pa_oe  in/out/out  PA_W each  port A pad input, output value, output enable
pb_in/pb_out/pb_oe  in/out/out  PB_W each  port B
pc_in/pc_out/pc_oe  in/out/out  PC_W each  port C
irq  out  1  active-high interrupt request

Behaviour:
- Clock and reset: one clock `phi2`; reset is synchronous and active-high. While `reset`=1 at a rising edge, PRA/PRB/PRC/DDRA/DDRB/DDRC/CR/latches/synchronisers all become 0. Consequences: all *_oe=0, irq=0, rdata_oe follows cs/we.
- Register map (rs):
  - 0 PRA, 1 PRB, 2 PRC, 3 DDRA, 4 DDRB, 5 DDRC, 6 CR, 7 AIR.
  - Writes take effect at the edge of the cs&we cycle.
  - Bits above port width are stored but never drive pads.
- Port pads:
  - x_out = PRx; x_oe = DDRx (bit-wise, 1 = output).
  - Port read returns `(DDR & PR) | (~DDR & sync_in)`, masked to width. Unimplemented bits read 0.
  - Input read latency = SYNC_STAGES cycles.
- CR[7] = MC (mode).
  - When PC_W<8, MC write is ignored and reads 0.
  - MC=0: port C plain GPIO.
  - MC=1: PC[4:0] are forced inputs (oe=0 regardless of DDRC); DDRC[4:0] becomes the interrupt mask.
- Interrupt latches (MC=1):
  - A falling edge on synchronised PC[i] (i=0..4) sets latch[i].
  - CA edge on sync PC6 sets latch bit 5; CR[1]=0 selects falling edge, 1 selects rising.
  - Latch mask: bits 4:0 use DDRC[4:0]; bit 5 uses CR[0].
  - PRC read in MC=1 returns latches in bits [5:0] and sync PC7 in bit 7.
- AIR: one-hot highest pending unmasked latch; priority bit5 > bit4 > … > bit0; reads 0 if none.
  - Write to rs=7 (any data) clears exactly the latch shown in AIR at that cycle.
  - A new edge on the same bit in the same cycle wins: the latch stays set.
  - irq = MC & (AIR != 0), registered with 1-cycle latency.
- CB output (PC7, MC=1, oe forced 1):
  - CR[5]=0: PC7 = CR[4] static.
  - CR[5]=1 handshake: PC7 idles high, goes low on the cycle after any PRA access (read or write), returns high after one cycle.
  - Back-to-back PRA accesses keep it low continuously.
- Switching MC 1→0 clears all latches and drops irq the next cycle.
- rs=6 read returns CR. rs values outside the map do not exist (3-bit fully decoded).

Optional Feature:
- Macro: TPI_DDR_READBACK_MASK_EN.
- Defined: DDRA/DDRB/DDRC reads return bits above port width as 0. PC_W<8 also forces CR[7] read 0 (already required).
- Undefined: DDR reads return the full stored 8-bit value (legacy 6523 software compatibility).

Test Plan:
- Reset: assert reset 2 cycles with pads floating → all oe=0, irq=0, reads of rs0..7 return 0 (PRx reads reflect pad inputs after SYNC_STAGES).
- GPIO: write DDRA=0xF0, PRA=0xA5; pa_in=0x3C → pa_oe=0xF0, pa_out=0xA5, PRA read=0xAC after 2 cycles.
- Width: PB_W=2, write DDRB=0xFF, PRB=0xFF → pb_oe=2'b11; PRB read=0x03; DDRB read=0x03 with macro, 0xFF without.
- Interrupt priority: MC=1, DDRC=0x1F; falling edges on PC1 and PC4 same cycle → AIR=0x10, irq=1 one cycle later; write AIR → AIR=0x02; write AIR → AIR=0, irq=0.
- Masking and race: DDRC[2]=0, edge on PC2 → latch set, irq=0; set DDRC[2]=1 → irq=1. Write AIR coincident with new PC2 edge → latch remains set.
- Handshake: CR=0xA0, read PRA → PC7 low exactly one cycle; two consecutive PRA accesses → low two cycles. Set MC=0 with latches pending → latches cleared, irq=0 next cycle.

Source files
------------

// File: rtl/tpi_port_core.sv
`default_nettype none
// ============================================================================
// Module   : tpi_port_core
// Brief    : 6523-style triple GPIO port with direction registers, latched
//            edge interrupts on PC[4:0]/CA, prioritised AIR and CB handshake.
//            Optional macro TPI_DDR_READBACK_MASK_EN masks DDR readback to
//            the implemented port width.
// Revision : 1.0
// ============================================================================
module tpi_port_core #(
    parameter int PA_W        = 8,
    parameter int PB_W        = 8,
    parameter int PC_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            phi2,
    input  logic            reset,
    input  logic            cs,
    input  logic            we,
    input  logic [2:0]      rs,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic            rdata_oe,
    input  logic [PA_W-1:0] pa_in,
    output logic [PA_W-1:0] pa_out,
    output logic [PA_W-1:0] pa_oe,
    input  logic [PB_W-1:0] pb_in,
    output logic [PB_W-1:0] pb_out,
    output logic [PB_W-1:0] pb_oe,
    input  logic [PC_W-1:0] pc_in,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_oe,
    output logic            irq
);

    localparam logic [2:0] c_RS_PRA  = 3'd0;
    localparam logic [2:0] c_RS_PRB  = 3'd1;
    localparam logic [2:0] c_RS_PRC  = 3'd2;
    localparam logic [2:0] c_RS_DDRA = 3'd3;
    localparam logic [2:0] c_RS_DDRB = 3'd4;
    localparam logic [2:0] c_RS_DDRC = 3'd5;
    localparam logic [2:0] c_RS_CR   = 3'd6;
    localparam logic [2:0] c_RS_AIR  = 3'd7;

    localparam logic [7:0] c_PA_MASK = 8'((16'd1 << PA_W) - 16'd1);
    localparam logic [7:0] c_PB_MASK = 8'((16'd1 << PB_W) - 16'd1);
    localparam logic [7:0] c_PC_MASK = 8'((16'd1 << PC_W) - 16'd1);
    localparam logic       c_MC_OK   = (PC_W == 8);

    logic [7:0]      r_pra, r_prb, r_prc;
    logic [7:0]      r_ddra, r_ddrb, r_ddrc;
    logic [7:0]      r_cr;
    logic [5:0]      r_latch;
    logic [4:0]      r_pcl_prev;
    logic            r_ca_prev;
    logic            r_cb;
    logic            r_irq;
    logic [PA_W-1:0] r_pa_sync [SYNC_STAGES];
    logic [PB_W-1:0] r_pb_sync [SYNC_STAGES];
    logic [PC_W-1:0] r_pc_sync [SYNC_STAGES];

    logic [7:0] w_pa_s, w_pb_s, w_pc_s;
    logic [7:0] w_cr_wdata;
    logic       w_wr, w_mc, w_mc_clr, w_air_wr, w_pra_acc, w_ca_edge;
    logic [4:0] w_pcl_fall;
    logic [5:0] w_set, w_pend, w_air, w_air_clr;
    logic [7:0] w_pra_rd, w_prb_rd, w_prc_rd, w_prc_gpio;
    logic [7:0] w_ddra_rd, w_ddrb_rd, w_ddrc_rd;
    logic [7:0] w_pc_out8, w_pc_oe8;

    assign w_wr       = cs & we;
    assign w_mc       = r_cr[7];
    assign w_pra_acc  = cs & (rs == c_RS_PRA);
    assign w_air_wr   = w_wr & (rs == c_RS_AIR);
    assign w_cr_wdata = {wdata[7] & c_MC_OK, wdata[6:0]};
    assign w_mc_clr   = w_wr & (rs == c_RS_CR) & ~w_cr_wdata[7];
    assign rdata_oe   = cs & ~we;

    // Input synchronisers; the last stage is the architecturally visible pin value
    always_ff @(posedge phi2) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_pa_sync[i] <= '0;
                r_pb_sync[i] <= '0;
                r_pc_sync[i] <= '0;
            end
        end else begin
            r_pa_sync[0] <= pa_in;
            r_pb_sync[0] <= pb_in;
            r_pc_sync[0] <= pc_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_pa_sync[i] <= r_pa_sync[i-1];
                r_pb_sync[i] <= r_pb_sync[i-1];
                r_pc_sync[i] <= r_pc_sync[i-1];
            end
        end
    end

    always_comb begin
        w_pa_s = '0;
        w_pb_s = '0;
        w_pc_s = '0;
        w_pa_s[PA_W-1:0] = r_pa_sync[SYNC_STAGES-1];
        w_pb_s[PB_W-1:0] = r_pb_sync[SYNC_STAGES-1];
        w_pc_s[PC_W-1:0] = r_pc_sync[SYNC_STAGES-1];
    end

    always_ff @(posedge phi2) begin
        if (reset) begin
            r_pra  <= '0;
            r_prb  <= '0;
            r_prc  <= '0;
            r_ddra <= '0;
            r_ddrb <= '0;
            r_ddrc <= '0;
            r_cr   <= '0;
        end else if (w_wr) begin
            case (rs)
                c_RS_PRA:  r_pra  <= wdata;
                c_RS_PRB:  r_prb  <= wdata;
                c_RS_PRC:  r_prc  <= wdata;
                c_RS_DDRA: r_ddra <= wdata;
                c_RS_DDRB: r_ddrb <= wdata;
                c_RS_DDRC: r_ddrc <= wdata;
                c_RS_CR:   r_cr   <= w_cr_wdata;
                default:   ;
            endcase
        end
    end

    // Edge detection against the previous synchronised sample
    assign w_pcl_fall = r_pcl_prev & ~w_pc_s[4:0];
    assign w_ca_edge  = r_cr[1] ? (~r_ca_prev & w_pc_s[6]) : (r_ca_prev & ~w_pc_s[6]);
    assign w_set      = {w_ca_edge, w_pcl_fall};
    assign w_pend     = r_latch & {r_cr[0], r_ddrc[4:0]};

    always_comb begin
        w_air = '0;
        for (int i = 0; i < 6; i++) begin
            if (w_pend[i]) begin
                w_air    = '0;
                w_air[i] = 1'b1;
            end
        end
    end

    assign w_air_clr = w_air_wr ? w_air : 6'd0;

    always_ff @(posedge phi2) begin
        if (reset) begin
            r_pcl_prev <= '0;
            r_ca_prev  <= 1'b0;
            r_latch    <= '0;
            r_irq      <= 1'b0;
            r_cb       <= 1'b1;
        end else begin
            r_pcl_prev <= w_pc_s[4:0];
            r_ca_prev  <= w_pc_s[6];
            r_cb       <= ~w_pra_acc;
            if (!w_mc || w_mc_clr) begin
                r_latch <= '0;
            end else begin
                // A fresh edge wins over the acknowledge of the same bit
                r_latch <= (r_latch & ~w_air_clr) | w_set;
            end
            r_irq <= w_mc_clr ? 1'b0 : (w_mc & (|w_air));
        end
    end

    assign irq = r_irq;

    assign w_pra_rd   = ((r_ddra & r_pra) | (~r_ddra & w_pa_s)) & c_PA_MASK;
    assign w_prb_rd   = ((r_ddrb & r_prb) | (~r_ddrb & w_pb_s)) & c_PB_MASK;
    assign w_prc_gpio = ((r_ddrc & r_prc) | (~r_ddrc & w_pc_s)) & c_PC_MASK;
    assign w_prc_rd   = w_mc ? {w_pc_s[7], 1'b0, r_latch} : w_prc_gpio;

`ifdef TPI_DDR_READBACK_MASK_EN
    assign w_ddra_rd = r_ddra & c_PA_MASK;
    assign w_ddrb_rd = r_ddrb & c_PB_MASK;
    assign w_ddrc_rd = r_ddrc & c_PC_MASK;
`else
    assign w_ddra_rd = r_ddra;
    assign w_ddrb_rd = r_ddrb;
    assign w_ddrc_rd = r_ddrc;
`endif

    always_comb begin
        rdata = '0;
        case (rs)
            c_RS_PRA:  rdata = w_pra_rd;
            c_RS_PRB:  rdata = w_prb_rd;
            c_RS_PRC:  rdata = w_prc_rd;
            c_RS_DDRA: rdata = w_ddra_rd;
            c_RS_DDRB: rdata = w_ddrb_rd;
            c_RS_DDRC: rdata = w_ddrc_rd;
            c_RS_CR:   rdata = r_cr;
            c_RS_AIR:  rdata = {2'b00, w_air};
            default:   rdata = '0;
        endcase
    end

    // Interrupt mode turns PC[4:0] into inputs and PC7 into the CB output
    always_comb begin
        w_pc_out8 = r_prc;
        w_pc_oe8  = r_ddrc;
        if (w_mc) begin
            w_pc_oe8[4:0] = 5'd0;
            w_pc_oe8[7]   = 1'b1;
            w_pc_out8[7]  = r_cr[5] ? r_cb : r_cr[4];
        end
    end

    assign pa_out = r_pra[PA_W-1:0];
    assign pa_oe  = r_ddra[PA_W-1:0];
    assign pb_out = r_prb[PB_W-1:0];
    assign pb_oe  = r_ddrb[PB_W-1:0];
    assign pc_out = w_pc_out8[PC_W-1:0];
    assign pc_oe  = w_pc_oe8[PC_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_tpi_port_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpi_port_core
// Brief    : Directed self-checking bench for tpi_port_core (full-width and
//            narrow instances sharing one CPU bus).
// Revision : 1.0
// ============================================================================
module tb_tpi_port_core;

    logic       phi2 = 1'b0;
    logic       reset, cs, we;
    logic [2:0] rs;
    logic [7:0] wdata;

    logic [7:0] rdata;
    logic       rdata_oe;
    logic [7:0] pa_in, pa_out, pa_oe;
    logic [7:0] pb_in, pb_out, pb_oe;
    logic [7:0] pc_in, pc_out, pc_oe;
    logic       irq;

    logic [7:0] n_rdata;
    logic       n_rdata_oe;
    logic [7:0] n_pa_in, n_pa_out, n_pa_oe;
    logic [1:0] n_pb_in, n_pb_out, n_pb_oe;
    logic [3:0] n_pc_in, n_pc_out, n_pc_oe;
    logic       n_irq;

    int errors = 0;
    int checks = 0;
    logic [7:0] d, dn;

`ifdef TPI_DDR_READBACK_MASK_EN
    localparam logic [7:0] c_N_DDRB_RD = 8'h03;
`else
    localparam logic [7:0] c_N_DDRB_RD = 8'hFF;
`endif

    always #5 phi2 = ~phi2;

    tpi_port_core #(.PA_W(8), .PB_W(8), .PC_W(8), .SYNC_STAGES(2)) u_dut (
        .phi2(phi2), .reset(reset), .cs(cs), .we(we), .rs(rs), .wdata(wdata),
        .rdata(rdata), .rdata_oe(rdata_oe),
        .pa_in(pa_in), .pa_out(pa_out), .pa_oe(pa_oe),
        .pb_in(pb_in), .pb_out(pb_out), .pb_oe(pb_oe),
        .pc_in(pc_in), .pc_out(pc_out), .pc_oe(pc_oe),
        .irq(irq)
    );

    tpi_port_core #(.PA_W(8), .PB_W(2), .PC_W(4), .SYNC_STAGES(1)) u_dut_n (
        .phi2(phi2), .reset(reset), .cs(cs), .we(we), .rs(rs), .wdata(wdata),
        .rdata(n_rdata), .rdata_oe(n_rdata_oe),
        .pa_in(n_pa_in), .pa_out(n_pa_out), .pa_oe(n_pa_oe),
        .pb_in(n_pb_in), .pb_out(n_pb_out), .pb_oe(n_pb_oe),
        .pc_in(n_pc_in), .pc_out(n_pc_out), .pc_oe(n_pc_oe),
        .irq(n_irq)
    );

    task automatic cyc();
        @(posedge phi2);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] v);
        cs = 1'b1; we = 1'b1; rs = a; wdata = v;
        cyc();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] v, output logic [7:0] vn);
        cs = 1'b1; we = 1'b0; rs = a;
        #1;
        v  = rdata;
        vn = n_rdata;
        cyc();
        cs = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (pa_oe !== 8'h00) begin errors++; $display("FAIL reset_pa_oe: got %h want 00", pa_oe); end
        checks++; if (pb_oe !== 8'h00) begin errors++; $display("FAIL reset_pb_oe: got %h want 00", pb_oe); end
        checks++; if (pc_oe !== 8'h00) begin errors++; $display("FAIL reset_pc_oe: got %h want 00", pc_oe); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d, dn);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_read rs=%0d: got %h want 00", i, d); end
        end
        cs = 1'b1; we = 1'b0; #1;
        checks++; if (rdata_oe !== 1'b1) begin errors++; $display("FAIL rdata_oe_read: got %b want 1", rdata_oe); end
        we = 1'b1; #1;
        checks++; if (rdata_oe !== 1'b0) begin errors++; $display("FAIL rdata_oe_write: got %b want 0", rdata_oe); end
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic test_gpio();
        wr(3'd3, 8'hF0);
        wr(3'd0, 8'hA5);
        pa_in = 8'h3C; n_pa_in = 8'h3C;
        checks++; if (pa_oe !== 8'hF0) begin errors++; $display("FAIL gpio_pa_oe: got %h want F0", pa_oe); end
        checks++; if (pa_out !== 8'hA5) begin errors++; $display("FAIL gpio_pa_out: got %h want A5", pa_out); end
        cyc();
        rd(3'd0, d, dn);
        checks++; if (d !== 8'hA0) begin errors++; $display("FAIL gpio_latency1: got %h want A0", d); end
        checks++; if (dn !== 8'hAC) begin errors++; $display("FAIL gpio_sync1_read: got %h want AC", dn); end
        rd(3'd0, d, dn);
        checks++; if (d !== 8'hAC) begin errors++; $display("FAIL gpio_latency2: got %h want AC", d); end
        rd(3'd3, d, dn);
        checks++; if (d !== 8'hF0) begin errors++; $display("FAIL gpio_ddra_read: got %h want F0", d); end
    endtask

    task automatic test_width();
        wr(3'd4, 8'hFF);
        wr(3'd1, 8'hFF);
        checks++; if (n_pb_oe !== 2'b11) begin errors++; $display("FAIL width_pb_oe: got %b want 11", n_pb_oe); end
        checks++; if (n_pb_out !== 2'b11) begin errors++; $display("FAIL width_pb_out: got %b want 11", n_pb_out); end
        rd(3'd1, d, dn);
        checks++; if (dn !== 8'h03) begin errors++; $display("FAIL width_prb_read: got %h want 03", dn); end
        rd(3'd4, d, dn);
        checks++; if (dn !== c_N_DDRB_RD) begin errors++; $display("FAIL width_ddrb_read: got %h want %h", dn, c_N_DDRB_RD); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL full_ddrb_read: got %h want FF", d); end
        wr(3'd6, 8'h80);
        rd(3'd6, d, dn);
        checks++; if (dn !== 8'h00) begin errors++; $display("FAIL width_mc_ignored: got %h want 00", dn); end
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL full_cr_read: got %h want 80", d); end
        wr(3'd6, 8'h00);
    endtask

    task automatic test_irq_priority();
        pc_in = 8'hFF;
        cyc(); cyc(); cyc();
        wr(3'd5, 8'h1F);
        wr(3'd6, 8'h80);
        checks++; if (pc_oe !== 8'h80) begin errors++; $display("FAIL mc_pc_oe: got %h want 80", pc_oe); end
        pc_in = 8'hED;
        cyc(); cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_irq_early: got %b want 0", irq); end
        cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_irq_latency: got %b want 0", irq); end
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h10) begin errors++; $display("FAIL prio_air_first: got %h want 10", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq_set: got %b want 1", irq); end
        rd(3'd2, d, dn);
        checks++; if (d !== 8'h92) begin errors++; $display("FAIL prio_prc_latches: got %h want 92", d); end
        wr(3'd7, 8'hFF);
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL prio_air_second: got %h want 02", d); end
        wr(3'd7, 8'h00);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_irq_hold: got %b want 1", irq); end
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL prio_air_empty: got %h want 00", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL prio_irq_clear: got %b want 0", irq); end
        pc_in = 8'hFF;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_mask_race();
        wr(3'd5, 8'h1B);
        pc_in = 8'hFB;
        cyc(); cyc(); cyc(); cyc();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b want 0", irq); end
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mask_air: got %h want 00", d); end
        rd(3'd2, d, dn);
        checks++; if (d !== 8'h84) begin errors++; $display("FAIL mask_latch: got %h want 84", d); end
        wr(3'd5, 8'h1F);
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL unmask_air: got %h want 04", d); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b want 1", irq); end
        pc_in = 8'hFF;
        cyc(); cyc(); cyc();
        pc_in = 8'hFB;
        cyc(); cyc();
        wr(3'd7, 8'h00);
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL race_latch_kept: got %h want 04", d); end
        wr(3'd7, 8'h00);
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL race_ack: got %h want 00", d); end
    endtask

    task automatic test_mc_clear();
        pc_in = 8'hFF;
        cyc(); cyc(); cyc();
        pc_in = 8'hFB;
        cyc(); cyc(); cyc();
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h04) begin errors++; $display("FAIL mcclr_pending: got %h want 04", d); end
        cyc();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mcclr_irq_before: got %b want 1", irq); end
        wr(3'd6, 8'h00);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mcclr_irq_after: got %b want 0", irq); end
        wr(3'd6, 8'h80);
        rd(3'd7, d, dn);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mcclr_latches: got %h want 00", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mcclr_irq_reenable: got %b want 0", irq); end
    endtask

    task automatic test_handshake();
        wr(3'd6, 8'hA0);
        checks++; if (pc_out[7] !== 1'b1) begin errors++; $display("FAIL cb_idle: got %b want 1", pc_out[7]); end
        rd(3'd0, d, dn);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL cb_pulse: got %b want 0", pc_out[7]); end
        cyc();
        checks++; if (pc_out[7] !== 1'b1) begin errors++; $display("FAIL cb_release: got %b want 1", pc_out[7]); end
        rd(3'd0, d, dn);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL cb_b2b_first: got %b want 0", pc_out[7]); end
        rd(3'd0, d, dn);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL cb_b2b_second: got %b want 0", pc_out[7]); end
        cyc();
        checks++; if (pc_out[7] !== 1'b1) begin errors++; $display("FAIL cb_b2b_release: got %b want 1", pc_out[7]); end
        wr(3'd0, 8'h5A);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL cb_write_pulse: got %b want 0", pc_out[7]); end
        wr(3'd6, 8'h90);
        rd(3'd0, d, dn);
        checks++; if (pc_out[7] !== 1'b1) begin errors++; $display("FAIL cb_static_high: got %b want 1", pc_out[7]); end
        wr(3'd6, 8'h80);
        checks++; if (pc_out[7] !== 1'b0) begin errors++; $display("FAIL cb_static_low: got %b want 0", pc_out[7]); end
        wr(3'd6, 8'h00);
        checks++; if (pc_oe !== 8'h1F) begin errors++; $display("FAIL gpio_pc_oe_restore: got %h want 1F", pc_oe); end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; rs = 3'd0; wdata = 8'h00;
        pa_in = 8'h00; pb_in = 8'h00; pc_in = 8'h00;
        n_pa_in = 8'h00; n_pb_in = 2'b00; n_pc_in = 4'h0;
        test_reset();
        test_gpio();
        test_width();
        test_irq_priority();
        test_mask_race();
        test_mc_clear();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
